// File: rtl/sim_result_monitor.sv
// Bus-snooping test-result monitor: latches mailbox writes, buffers log words,
// and reports a sticky done/pass/fail/timeout verdict for benches and FPGA builds.
module sim_result_monitor #(
    parameter logic [31:0] P_BASE_ADDR   = 32'h0002_0000,
    parameter int          P_LOG_DEPTH   = 16,
    parameter int          P_LOG_DEPTH_N = 4,
    parameter logic [31:0] P_TIMEOUT     = 32'd75_000_000
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iMEMORY_REQ,
    input  logic                     iMEMORY_LOCK,
    input  logic [1:0]               iMEMORY_ORDER,
    input  logic                     iMEMORY_RW,
    input  logic [31:0]              iMEMORY_ADDR,
    input  logic [31:0]              iMEMORY_DATA,
    output logic                     oDONE,
    output logic                     oPASS,
    output logic                     oFAIL,
    output logic                     oTIMEOUT,
    output logic [31:0]              oERR_TYPE,
    output logic [31:0]              oERR_NUMBER,
    output logic [31:0]              oERR_RESULT,
    output logic [31:0]              oERR_EXPECT,
    output logic                     oLOG_VALID,
    output logic [31:0]              oLOG_DATA,
    input  logic                     iLOG_ACK,
    output logic [P_LOG_DEPTH_N:0]   oLOG_COUNT,
    output logic                     oLOG_OVERFLOW,
    output logic [1:0]               oDEBUG_STATE
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FIN_PASS = 2'd1,
        ST_FIN_FAIL = 2'd2,
        ST_TMO      = 2'd3
    } state_t;

    localparam logic [P_LOG_DEPTH_N:0]   DEPTH_C = (P_LOG_DEPTH_N + 1)'(P_LOG_DEPTH);
    localparam logic [P_LOG_DEPTH_N:0]   CNT_ONE = 1;
    localparam logic [P_LOG_DEPTH_N-1:0] PTR_ONE = 1;

    state_t                   state, state_next;
    logic                     flag;
    logic [31:0]              wd_count;
    logic                     wd_expire;
    logic                     accept;
    logic                     running;
    logic                     wr_en;
    logic [4:0]               offset;
    logic [31:0]              swapped;
    logic                     finish_wr;

    logic [31:0]              log_mem [P_LOG_DEPTH];
    logic [P_LOG_DEPTH_N-1:0] wr_ptr;
    logic [P_LOG_DEPTH_N-1:0] rd_ptr;
    logic [P_LOG_DEPTH_N:0]   count;
    logic                     log_full;
    logic                     push_req;
    logic                     do_push;
    logic                     do_pop;

    assign accept = iMEMORY_REQ && !iMEMORY_LOCK && iMEMORY_RW &&
                    (iMEMORY_ORDER == 2'h2) &&
                    (iMEMORY_ADDR[31:5] == P_BASE_ADDR[31:5]) &&
                    (iMEMORY_ADDR[1:0] == 2'b00);
    assign running   = (state == ST_RUN);
    assign wr_en     = accept && running;
    assign offset    = iMEMORY_ADDR[4:0];
    assign swapped   = {iMEMORY_DATA[7:0], iMEMORY_DATA[15:8],
                        iMEMORY_DATA[23:16], iMEMORY_DATA[31:24]};
    assign finish_wr = wr_en && (offset == 5'h04);
    assign wd_expire = (P_TIMEOUT != 32'd0) && (wd_count == P_TIMEOUT - 32'd1);

    // Verdict FSM: a finish write takes priority over a same-cycle watchdog expiry.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (finish_wr) begin
                    state_next = flag ? ST_FIN_PASS : ST_FIN_FAIL;
                end else if (wd_expire) begin
                    state_next = ST_TMO;
                end
            end
            default: state_next = state;
        endcase
    end

    assign oDONE        = (state != ST_RUN);
    assign oPASS        = (state == ST_FIN_PASS);
    assign oFAIL        = (state == ST_FIN_FAIL) || (state == ST_TMO);
    assign oTIMEOUT     = (state == ST_TMO);
    assign oDEBUG_STATE = state;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wd_count <= 32'd0;
        end else if (running && (P_TIMEOUT != 32'd0)) begin
            wd_count <= wd_count + 32'd1;
        end
    end

    // Mailbox registers; the flag bit is D[24], i.e. bit 0 of the byte-swapped word.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            flag        <= 1'b0;
            oERR_TYPE   <= 32'd0;
            oERR_NUMBER <= 32'd0;
            oERR_RESULT <= 32'd0;
            oERR_EXPECT <= 32'd0;
        end else if (wr_en) begin
            case (offset)
                5'h00:   flag        <= iMEMORY_DATA[24];
                5'h0C:   oERR_TYPE   <= swapped;
                5'h10:   oERR_NUMBER <= swapped;
                5'h14:   oERR_RESULT <= swapped;
                5'h18:   oERR_EXPECT <= swapped;
                default: ;
            endcase
        end
    end

    // Log FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
    assign log_full = (count == DEPTH_C);
    assign push_req = wr_en && (offset == 5'h08);
    assign do_pop   = iLOG_ACK && (count != '0);
    assign do_push  = push_req && (!log_full || do_pop);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            oLOG_OVERFLOW <= 1'b0;
            for (int i = 0; i < P_LOG_DEPTH; i++) begin
                log_mem[i] <= 32'd0;
            end
        end else begin
            if (do_push) begin
                log_mem[wr_ptr] <= swapped;
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
            if (push_req && !do_push) begin
                oLOG_OVERFLOW <= 1'b1;
            end
        end
    end

    assign oLOG_VALID = (count != '0);
    assign oLOG_DATA  = log_mem[rd_ptr];
    assign oLOG_COUNT = count;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Self-checking bench for sim_result_monitor: directed mailbox/FIFO/watchdog cases
// plus randomized bus traffic compared every cycle against a behavioural model.
module tb_sim_result_monitor;

    localparam logic [31:0] BASE  = 32'h0002_0000;
    localparam logic [31:0] TMO   = 32'd100;
    localparam int          DEPTH = 16;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iMEMORY_REQ = 1'b0;
    logic        iMEMORY_LOCK = 1'b0;
    logic [1:0]  iMEMORY_ORDER = 2'h3;
    logic        iMEMORY_RW = 1'b0;
    logic [31:0] iMEMORY_ADDR = 32'd0;
    logic [31:0] iMEMORY_DATA = 32'd0;
    logic        iLOG_ACK = 1'b0;
    logic        oDONE, oPASS, oFAIL, oTIMEOUT;
    logic [31:0] oERR_TYPE, oERR_NUMBER, oERR_RESULT, oERR_EXPECT;
    logic        oLOG_VALID;
    logic [31:0] oLOG_DATA;
    logic [4:0]  oLOG_COUNT;
    logic        oLOG_OVERFLOW;
    logic [1:0]  oDEBUG_STATE;

    int checks = 0;
    int errors = 0;

    sim_result_monitor #(
        .P_BASE_ADDR  (BASE),
        .P_LOG_DEPTH  (DEPTH),
        .P_LOG_DEPTH_N(4),
        .P_TIMEOUT    (TMO)
    ) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iMEMORY_REQ  (iMEMORY_REQ),
        .iMEMORY_LOCK (iMEMORY_LOCK),
        .iMEMORY_ORDER(iMEMORY_ORDER),
        .iMEMORY_RW   (iMEMORY_RW),
        .iMEMORY_ADDR (iMEMORY_ADDR),
        .iMEMORY_DATA (iMEMORY_DATA),
        .oDONE        (oDONE),
        .oPASS        (oPASS),
        .oFAIL        (oFAIL),
        .oTIMEOUT     (oTIMEOUT),
        .oERR_TYPE    (oERR_TYPE),
        .oERR_NUMBER  (oERR_NUMBER),
        .oERR_RESULT  (oERR_RESULT),
        .oERR_EXPECT  (oERR_EXPECT),
        .oLOG_VALID   (oLOG_VALID),
        .oLOG_DATA    (oLOG_DATA),
        .iLOG_ACK     (iLOG_ACK),
        .oLOG_COUNT   (oLOG_COUNT),
        .oLOG_OVERFLOW(oLOG_OVERFLOW),
        .oDEBUG_STATE (oDEBUG_STATE)
    );

    always #5 iCLOCK = ~iCLOCK;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: verdict bits, mailbox words, log queue, edges since reset release.
    logic        m_flag, m_done, m_pass, m_fail, m_tmo, m_ovf;
    logic [31:0] m_err [4];
    logic [31:0] log_q [$];
    int          edges;

    initial begin
        m_flag = 0; m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) m_err[i] = 32'd0;
        edges = 0;
    end

    always @(posedge iCLOCK or negedge inRESET) begin
        logic hit, fin, full, pop, push;
        int   off;
        if (!inRESET) begin
            m_flag = 0; m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0;
            for (int i = 0; i < 4; i++) m_err[i] = 32'd0;
            log_q.delete();
            edges = 0;
        end else begin
            edges++;
            hit = iMEMORY_REQ && !iMEMORY_LOCK && iMEMORY_RW && (iMEMORY_ORDER == 2'h2) &&
                  (iMEMORY_ADDR[31:5] == BASE[31:5]) && (iMEMORY_ADDR[1:0] == 2'b00);
            off  = int'(iMEMORY_ADDR[4:0]);
            full = (log_q.size() == DEPTH);
            pop  = iLOG_ACK && (log_q.size() != 0);
            push = 0;
            fin  = 0;
            if (!m_done) begin
                if (hit) begin
                    case (off)
                        'h00: m_flag = iMEMORY_DATA[24];
                        'h04: fin = 1;
                        'h08: push = 1;
                        'h0C: m_err[0] = bswap(iMEMORY_DATA);
                        'h10: m_err[1] = bswap(iMEMORY_DATA);
                        'h14: m_err[2] = bswap(iMEMORY_DATA);
                        'h18: m_err[3] = bswap(iMEMORY_DATA);
                        default: ;
                    endcase
                end
                if (fin) begin
                    m_done = 1;
                    m_pass = m_flag;
                    m_fail = !m_flag;
                end else if (edges == int'(TMO)) begin
                    m_done = 1; m_fail = 1; m_tmo = 1;
                end
            end
            if (pop) void'(log_q.pop_front());
            if (push) begin
                if (!full || pop) log_q.push_back(bswap(iMEMORY_DATA));
                else m_ovf = 1;
            end
        end
    end

    always @(negedge iCLOCK) begin
        chk("done", 32'(oDONE), 32'(m_done));
        chk("pass", 32'(oPASS), 32'(m_pass));
        chk("fail", 32'(oFAIL), 32'(m_fail));
        chk("timeout", 32'(oTIMEOUT), 32'(m_tmo));
        chk("err_type", oERR_TYPE, m_err[0]);
        chk("err_number", oERR_NUMBER, m_err[1]);
        chk("err_result", oERR_RESULT, m_err[2]);
        chk("err_expect", oERR_EXPECT, m_err[3]);
        chk("log_count", 32'(oLOG_COUNT), 32'(log_q.size()));
        chk("log_valid", 32'(oLOG_VALID), 32'(log_q.size() != 0));
        chk("log_overflow", 32'(oLOG_OVERFLOW), 32'(m_ovf));
        if (log_q.size() != 0) chk("log_data", oLOG_DATA, log_q[0]);
    end

    task automatic drive(input logic r, input logic lk, input logic w, input logic [1:0] ord,
                         input logic [31:0] a, input logic [31:0] d, input logic ak);
        @(negedge iCLOCK);
        iMEMORY_REQ = r; iMEMORY_LOCK = lk; iMEMORY_RW = w; iMEMORY_ORDER = ord;
        iMEMORY_ADDR = a; iMEMORY_DATA = d; iLOG_ACK = ak;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, 2'h2, a, d, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'h3, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge iCLOCK);
        #2;
        inRESET = 1'b0;
        iMEMORY_REQ = 0; iMEMORY_LOCK = 0; iMEMORY_RW = 0; iMEMORY_ORDER = 2'h3;
        iMEMORY_ADDR = 0; iMEMORY_DATA = 0; iLOG_ACK = 0;
        @(negedge iCLOCK);
        @(negedge iCLOCK);
        #2;
        inRESET = 1'b1;
    endtask

    task automatic rand_cycle(input int ack_mod);
        logic [31:0] a;
        logic [31:0] d;
        int sel, o, slot;
        sel = $urandom_range(0, 9);
        o = $urandom_range(0, 11);
        case (o)
            0:                slot = 0;
            1, 2, 3, 4, 5:    slot = 2;
            6:                slot = 3;
            7:                slot = 4;
            8:                slot = 5;
            9:                slot = 6;
            10:               slot = 7;
            default:          slot = ($urandom_range(0, 4) == 0) ? 1 : 0;
        endcase
        if (sel == 0)      a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
        else if (sel == 1) a = BASE + 32'(slot * 4) + 32'($urandom_range(1, 3));
        else if (sel == 2) a = $urandom();
        else               a = BASE + 32'(slot * 4);
        d = $urandom();
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'h2,
              a, d, $urandom_range(0, ack_mod - 1) == 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        idle();
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_count", 32'(oLOG_COUNT), 32'd0);
        chk("rst_valid", 32'(oLOG_VALID), 32'd0);
        chk("rst_err_type", oERR_TYPE, 32'd0);

        // Passing finish
        do_reset();
        wr(BASE, 32'h0100_0000);
        wr(BASE + 32'h4, 32'hDEAD_BEEF);
        idle();
        chk("pass_done", 32'(oDONE), 32'd1);
        chk("pass_pass", 32'(oPASS), 32'd1);
        chk("pass_fail", 32'(oFAIL), 32'd0);

        // Failing finish with error words
        do_reset();
        wr(BASE + 32'hC, 32'h0500_0000);
        wr(BASE + 32'h14, 32'h7856_3412);
        wr(BASE, 32'h0000_0000);
        wr(BASE + 32'h4, 32'h0);
        idle();
        chk("fail_err_type", oERR_TYPE, 32'd5);
        chk("fail_err_result", oERR_RESULT, 32'h1234_5678);
        chk("fail_fail", 32'(oFAIL), 32'd1);
        chk("fail_pass", 32'(oPASS), 32'd0);

        // Non-accepted finish attempts
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 2'h0, BASE + 32'h4, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'h2, BASE + 32'h4, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 2'h2, BASE + 32'h4, 32'h0, 1'b0);
        idle();
        chk("ignored_done", 32'(oDONE), 32'd0);

        // Overflow then drain
        do_reset();
        for (int i = 1; i <= 17; i++) wr(BASE + 32'h8, bswap(32'(i)));
        idle();
        chk("ovf_count", 32'(oLOG_COUNT), 32'd16);
        chk("ovf_flag", 32'(oLOG_OVERFLOW), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 2'h3, 32'd0, 32'd0, 1'b1);
            chk("drain_data", oLOG_DATA, 32'(i));
        end
        idle();
        chk("drain_valid", 32'(oLOG_VALID), 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 16; i++) wr(BASE + 32'h8, bswap(32'(i)));
        drive(1'b1, 1'b0, 1'b1, 2'h2, BASE + 32'h8, bswap(32'd100), 1'b1);
        idle();
        chk("fullpp_count", 32'(oLOG_COUNT), 32'd16);
        chk("fullpp_ovf", 32'(oLOG_OVERFLOW), 32'd0);
        chk("fullpp_head", oLOG_DATA, 32'd2);

        // Watchdog expiry exactly TMO edges after release
        do_reset();
        repeat (99) idle();
        chk("tmo_before", 32'(oTIMEOUT), 32'd0);
        idle();
        chk("tmo_at", 32'(oTIMEOUT), 32'd1);
        chk("tmo_fail", 32'(oFAIL), 32'd1);
        chk("tmo_done", 32'(oDONE), 32'd1);
        wr(BASE, 32'h0100_0000);
        wr(BASE + 32'h4, 32'h0);
        idle();
        chk("tmo_late_pass", 32'(oPASS), 32'd0);
        chk("tmo_late_tmo", 32'(oTIMEOUT), 32'd1);

        // Randomized traffic, alternating light and heavy log draining
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            repeat (150) rand_cycle((ep % 2 == 0) ? 10 : 3);
            idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
- Synthesizable monitor on the core-to-memory bus, downstream of the core's memory port and in parallel with the memory model.
- Snoops accepted word writes to a test-result mailbox window and latches the pass flag, error type/number/result/expect words.
- Buffers log words in a FIFO and raises done/pass/fail, plus a watchdog timeout, so system-level benches and FPGA builds read a verdict without $display code.

Parameters:
P_BASE_ADDR, 32'h0002_0000, mailbox base address (word aligned).
P_LOG_DEPTH, 16, log FIFO entries; power of two.
P_LOG_DEPTH_N, 4, log2(P_LOG_DEPTH).
P_TIMEOUT, 32'd75_000_000, cycles to wait for a finish write before declaring timeout; 0 disables the watchdog.

Ports:
iCLOCK  in  1  clock; all state changes on rising edge.
inRESET  in  1  asynchronous active-low reset.
iMEMORY_REQ  in  1  bus request (snooped).
iMEMORY_LOCK  in  1  memory busy; a request is not accepted while high.
iMEMORY_ORDER  in  2  00=byte, 01=half, 10=word, 11=none.
iMEMORY_RW  in  1  1=write, 0=read.
iMEMORY_ADDR  in  32  byte address.
iMEMORY_DATA  in  32  write data, big-endian byte lanes.
oDONE  out  1  sticky; the test has ended (finish write or timeout).
oPASS  out  1  sticky; the test ended with flag=1.
oFAIL  out  1  sticky; the test ended with flag=0 or by timeout.
oTIMEOUT  out  1  sticky; the watchdog expired.
oERR_TYPE  out  32  last error-type word.
oERR_NUMBER  out  32  last error-index word.
oERR_RESULT  out  32  last result word.
oERR_EXPECT  out  32  last expect word.
oLOG_VALID  out  1  log FIFO is not empty.
oLOG_DATA  out  32  FIFO head (first-word fall-through).
iLOG_ACK  in  1  pops the head when oLOG_VALID=1.
oLOG_COUNT  out  P_LOG_DEPTH_N+1  FIFO occupancy.
oLOG_OVERFLOW  out  1  sticky; a log write was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, inRESET=0): all outputs are 0, all registers are 0, the FIFO is empty, the flag register is 0 and the watchdog counter is 0.
- Accept condition: iMEMORY_REQ & !iMEMORY_LOCK & iMEMORY_RW & iMEMORY_ORDER==2'h2 & ADDR[31:5]==P_BASE_ADDR[31:5] & ADDR[1:0]==0.
  - Reads, byte/half writes, and addresses outside the window are ignored.
- Swapped value V = {D[7:0],D[15:8],D[23:16],D[31:24]}.
- Offset decode (ADDR[4:0]):
  - 0x00: flag <= D[24] (the same bit as V[0]).
  - 0x04: finish.
  - 0x08: push V to the log FIFO.
  - 0x0C: oERR_TYPE <= V.
  - 0x10: oERR_NUMBER <= V.
  - 0x14: oERR_RESULT <= V.
  - 0x18: oERR_EXPECT <= V.
  - 0x1C: ignored.
- Latency: every register and the FIFO update on the edge that samples the accepted write; the result is visible one cycle later.
- State machine:
  - RUN → FIN_PASS on a finish write with flag=1: oDONE=1, oPASS=1.
  - RUN → FIN_FAIL on a finish write with flag=0: oDONE=1, oFAIL=1.
  - RUN → TMO when the watchdog counter reaches P_TIMEOUT-1 with no finish write: oDONE=1, oFAIL=1, oTIMEOUT=1.
  - All three end states are terminal until reset.
  - A finish write and watchdog expiry in the same cycle: finish wins.
- Watchdog counter: increments each cycle in RUN; frozen once oDONE=1; disabled when P_TIMEOUT==0.
- In the terminal states:
  - Mailbox writes, including flag, error words, further finish writes and log pushes, are ignored.
  - FIFO pops continue, so the host can drain the log after the end.
- FIFO rules:
  - Push when not full.
  - Push when full: data is dropped, oLOG_OVERFLOW is set, the count is unchanged.
  - iLOG_ACK with oLOG_VALID=0 is ignored.
  - Push and pop in the same cycle when full: both happen, count stays P_LOG_DEPTH, no overflow.
  - Push and pop in the same cycle when partially full: count unchanged.
  - Pointers wrap modulo P_LOG_DEPTH.

Test Plan:
- Write 0x01000000 to 0x20000, then any word to 0x20004 → oDONE=1 and oPASS=1 one cycle after the finish edge; oFAIL=0.
- Write 0x05000000 to 0x2000C, 0x78563412 to 0x20014, flag 0, then finish → oERR_TYPE=5, oERR_RESULT=0x12345678, oFAIL=1, oPASS=0.
- Write to 0x20004 with ORDER=2'h0, with RW=0, and with iMEMORY_LOCK=1 → no state change, oDONE remains 0.
- 17 log writes of values 1..17 with no ACK (P_LOG_DEPTH=16) → oLOG_COUNT=16, oLOG_OVERFLOW=1; draining with ACK yields 1..16 in order, then oLOG_VALID=0.
- FIFO full, push and ACK in the same cycle → count stays 16, no overflow, head advances.
- P_TIMEOUT=100, no finish write → oTIMEOUT=oFAIL=oDONE=1 exactly 100 cycles after reset release; a later finish write has no effect.
